// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer state encoding and instruction field positions.
package cpu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LI  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;
  localparam int OP_LSB = 6;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 2;
  localparam int RD_LSB = 0;
  localparam int IMM_W  = 4;
  localparam int OFF_W  = 6;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-fetch handshake plus register-unit read/write ports.
interface instr_sequencer_if #(parameter int PC_WIDTH = 8);
  logic                InstrReq;
  logic [PC_WIDTH-1:0] InstrAddr;
  logic                InstrValid;
  logic [7:0]          InstrData;
  logic [1:0]          ReadAddress1;
  logic [7:0]          ReadValue1;
  logic [1:0]          ReadAddress2;
  logic [7:0]          ReadValue2;
  logic                WriteControl;
  logic [1:0]          WriteAddress;
  logic [7:0]          WriteValue;
  modport master (
    output InstrReq, InstrAddr, ReadAddress1, ReadAddress2, WriteControl, WriteAddress, WriteValue,
    input  InstrValid, InstrData, ReadValue1, ReadValue2
  );
  modport slave (
    input  InstrReq, InstrAddr, ReadAddress1, ReadAddress2, WriteControl, WriteAddress, WriteValue,
    output InstrValid, InstrData, ReadValue1, ReadValue2
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: combinational ADD/SUB/LI datapath; carry is the sum carry or the subtract borrow.
module seq_alu
  import cpu_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [7:0]       opa,
  input  logic [7:0]       opb,
  input  logic [IMM_W-1:0] imm,
  output logic [7:0]       res,
  output logic             carry
);
  logic [8:0] sum, diff;
  always_comb begin
    sum   = {1'b0, opa} + {1'b0, opb};
    diff  = {1'b0, opa} - {1'b0, opb};
    res   = op == OP_ADD ? sum[7:0] :
            op == OP_SUB ? diff[7:0] :
            op == OP_LI  ? {{(8-IMM_W){imm[IMM_W-1]}}, imm} : 8'h00;
    carry = op == OP_SUB ? diff[8] : sum[8];
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute/writeback controller for the 4-register 8-bit CPU.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      Run,
  output logic                      Busy,
  output logic                      CarryFlag,
  instr_sequencer_if.master         bus
);
  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [7:0]          ir_q, opa_q, opb_q, result_q;
  logic                carry_q, req_q, we_q, busy_q;
  logic [1:0]          ra1_q, ra2_q, wa_q;
  logic [1:0]          op;
  logic [7:0]          alu_res;
  logic                alu_c;
  logic [PC_WIDTH-1:0] jmp_off;
  assign op      = ir_q[OP_LSB +: 2];
  assign jmp_off = {{(PC_WIDTH-OFF_W){ir_q[OFF_W-1]}}, ir_q[OFF_W-1:0]};
  seq_alu u_alu (
    .op   (op),
    .opa  (opa_q),
    .opb  (opb_q),
    .imm  (ir_q[IMM_W-1:0]),
    .res  (alu_res),
    .carry(alu_c)
  );
  // Every output is a register updated on the transition into the state that drives it.
  always_ff @(posedge CLK)
    if (!RSTn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      ra1_q    <= '0;
      ra2_q    <= '0;
      wa_q     <= '0;
    end else
      case (state_q)
        S_IDLE: if (Run) begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
        S_FETCH: if (bus.InstrValid) begin
          ir_q    <= bus.InstrData;
          ra1_q   <= bus.InstrData[RS_LSB +: 2];
          ra2_q   <= bus.InstrData[RT_LSB +: 2];
          req_q   <= 1'b0;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          opa_q   <= bus.ReadValue1;
          opb_q   <= bus.ReadValue2;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= alu_res;
          if (op == OP_ADD || op == OP_SUB) carry_q <= alu_c;
          if (op != OP_JMP) wa_q <= op == OP_LI ? ir_q[RS_LSB +: 2] : ir_q[RD_LSB +: 2];
          we_q    <= op != OP_JMP;
          state_q <= S_WB;
        end
        S_WB: begin
          we_q    <= 1'b0;
          pc_q    <= op == OP_JMP ? pc_q + jmp_off : pc_q + PC_WIDTH'(1);
          state_q <= Run ? S_FETCH : S_IDLE;
          req_q   <= Run;
          busy_q  <= Run;
        end
        default: state_q <= S_IDLE;
      endcase
  assign bus.InstrReq     = req_q;
  assign bus.InstrAddr    = pc_q;
  assign bus.ReadAddress1 = ra1_q;
  assign bus.ReadAddress2 = ra2_q;
  assign bus.WriteControl = we_q;
  assign bus.WriteAddress = wa_q;
  assign bus.WriteValue   = result_q;
  assign Busy             = busy_q;
  assign CarryFlag        = carry_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed program run against an instruction memory and register-unit model.
module tb_instr_sequencer;
  logic clk = 1'b0, rstn = 1'b0, run = 1'b0, valid = 1'b0, busy, carry;
  logic [7:0] mem [256];
  logic [7:0] regs [4];
  int total = 0, bad = 0;
  instr_sequencer_if #(.PC_WIDTH(8)) bus ();
  instr_sequencer #(.PC_WIDTH(8)) dut (
    .CLK(clk), .RSTn(rstn), .Run(run), .Busy(busy), .CarryFlag(carry), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.InstrValid = valid;
  assign bus.InstrData  = mem[bus.InstrAddr];
  assign bus.ReadValue1 = regs[bus.ReadAddress1];
  assign bus.ReadValue2 = regs[bus.ReadAddress2];
  always @(posedge clk) if (bus.WriteControl) regs[bus.WriteAddress] <= bus.WriteValue;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_wb(input string tag, input logic [1:0] a, input logic [7:0] v);
    int n = 0;
    do begin tick(); n++; end while (!bus.WriteControl && n < 12);
    check({tag, "_we"}, bus.WriteControl, 1);
    check({tag, "_wa"}, bus.WriteAddress, a);
    check({tag, "_wv"}, bus.WriteValue, v);
  endtask
  initial begin
    logic seen;
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h55;  mem[1] = 8'h58;  mem[2] = 8'h15;  mem[3] = 8'h64;
    mem[4] = 8'h2A;  mem[5] = 8'h2A;  mem[6] = 8'h2A;  mem[7] = 8'h1B;
    mem[8] = 8'hA4;  mem[9] = 8'h77;  mem[10] = 8'h43; mem[11] = 8'h15;
    run = 1'b1;
    valid = 1'b1;
    tick();
    tick();
    check("rst_req", bus.InstrReq, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", bus.InstrAddr, 0);
    check("rst_carry", carry, 0);
    check("rst_we", bus.WriteControl, 0);
    check("rst_wv", bus.WriteValue, 0);
    rstn = 1'b1;
    tick();
    check("f0_req", bus.InstrReq, 1);
    check("f0_busy", busy, 1);
    check("f0_addr", bus.InstrAddr, 0);
    check("f0_we", bus.WriteControl, 0);
    tick();
    check("d0_req", bus.InstrReq, 0);
    check("d0_ra1", bus.ReadAddress1, 1);
    check("d0_ra2", bus.ReadAddress2, 1);
    tick();
    check("e0_we", bus.WriteControl, 0);
    tick();
    check("li0_we", bus.WriteControl, 1);
    check("li0_wa", bus.WriteAddress, 1);
    check("li0_wv", bus.WriteValue, 8'h05);
    expect_wb("li_neg", 1, 8'hF8);
    expect_wb("add_r1", 1, 8'hF0);
    check("add_r1_c", carry, 1);
    expect_wb("li_r2", 2, 8'h04);
    expect_wb("dbl1", 2, 8'h08);
    check("dbl1_c", carry, 0);
    expect_wb("dbl2", 2, 8'h10);
    expect_wb("dbl3", 2, 8'h20);
    expect_wb("add_c", 3, 8'h10);
    check("add_c_c", carry, 1);
    expect_wb("sub_b", 0, 8'h30);
    check("sub_b_c", carry, 1);
    valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_req", bus.InstrReq, 1);
      check("stall_addr", bus.InstrAddr, 9);
      check("stall_we", bus.WriteControl, 0);
      tick();
    end
    valid = 1'b1;
    cyc = 5;
    do begin tick(); cyc++; end while (!bus.WriteControl && cyc < 20);
    check("stall_lat", cyc, 8);
    check("stall_wa", bus.WriteAddress, 3);
    check("stall_wv", bus.WriteValue, 8'h07);
    tick();
    check("drop_fetch", bus.InstrAddr, 10);
    tick();
    run = 1'b0;
    expect_wb("drop_wb", 0, 8'h03);
    tick();
    check("drop_busy", busy, 0);
    check("drop_req", bus.InstrReq, 0);
    check("drop_pc", bus.InstrAddr, 11);
    tick();
    tick();
    check("idle_hold", bus.InstrAddr, 11);
    run = 1'b1;
    tick();
    check("rx_fetch", bus.InstrAddr, 11);
    run = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rx_busy", busy, 0);
    check("rx_pc", bus.InstrAddr, 0);
    check("rx_carry", carry, 0);
    check("rx_we", bus.WriteControl, 0);
    check("rx_wv", bus.WriteValue, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= bus.WriteControl | bus.InstrReq;
      tick();
    end
    check("rx_quiet", seen, 0);
    check("rx_r1", regs[1], 8'hF0);
    mem[0] = 8'h41;
    mem[1] = 8'hFE;
    mem[255] = 8'h6F;
    run = 1'b1;
    expect_wb("j_li", 0, 8'h01);
    tick();
    check("j_fetch", bus.InstrAddr, 1);
    tick();
    tick();
    tick();
    check("j_nowe", bus.WriteControl, 0);
    tick();
    check("j_target", bus.InstrAddr, 8'hFF);
    expect_wb("wrap_li", 2, 8'hFF);
    tick();
    check("wrap_pc", bus.InstrAddr, 0);
    check("wrap_req", bus.InstrReq, 1);
    check("wrap_carry", carry, 0);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
